// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, over WIDTH cycles.
// Operands are captured on the accepted start edge; diff and borrow_out only update at completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // state | meaning
    // IDLE  | waiting for start; operands not yet captured
    // RUN   | one full-subtractor bit per edge, LSB first
    // DONE  | single-cycle completion pulse, then back to IDLE

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, pdiff;
    logic             borrow_q;
    logic [CW-1:0]    cnt;
    logic             d_bit, b_bit, last_bit;

    assign d_bit    = a_sr[0] ^ b_sr[0] ^ borrow_q;
    assign b_bit    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow_q);
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they line up with state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            pdiff      <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    pdiff    <= {d_bit, pdiff[WIDTH-1:1]};
                    borrow_q <= b_bit;
                    cnt      <= cnt + 1'b1;
                    if (last_bit) begin
                        diff       <= {d_bit, pdiff[WIDTH-1:1]};
                        borrow_out <= b_bit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, captured on the accepted start edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, captured on the accepted start edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse, high only in DONE.
REQ-009 The block SHALL have port diff, output, WIDTH bits: registered result a-b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit: registered final borrow, 1 when a<b unsigned.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE, all outputs registered.
REQ-012 In IDLE with start=1, the block SHALL, on that edge, load a and b into shift registers, clear the borrow flip-flop and bit counter, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE with no register change.
REQ-014 Each RUN edge SHALL process the LSB of each shift register as one full-subtractor bit: d = ai^bi^bin; bout = (~ai&bi) | (~(ai^bi)&bin).
REQ-015 Each RUN edge SHALL shift both operand registers right by one, shift d into the MSB of the partial-difference register, store bout in the borrow flip-flop, and increment the counter.
REQ-016 On the RUN edge processing bit WIDTH-1, the block SHALL load diff with the completed partial difference and borrow_out with bout, and enter DONE.
REQ-017 Latency SHALL be exactly WIDTH edges from the start-sampling edge to done high; done SHALL stay high for exactly one cycle, after which the FSM returns to IDLE.
REQ-018 start asserted in RUN or DONE SHALL be ignored, with no effect on the operation in progress or on the next IDLE cycle.
REQ-019 diff and borrow_out SHALL hold their last result through IDLE and the whole of any later RUN, changing only on the REQ-016 edge.
REQ-020 Changes on a and b after the accepted start edge SHALL NOT affect the result.
REQ-021 Start-to-start throughput SHALL be WIDTH+2 cycles minimum (RUN x WIDTH, DONE, IDLE).

Reset
REQ-022 While rst=1, the block SHALL force state IDLE, busy=0, done=0, diff=0, borrow_out=0, and clear the counter, borrow flip-flop and all shift registers, regardless of clk.
REQ-023 rst asserted mid-RUN SHALL abort the operation without producing a done pulse; the first start after reset release SHALL begin a fresh operation.

Verification
REQ-024 The bench SHALL cover: WIDTH=8, a=0x05, b=0x03, start pulse -> done exactly 8 edges later, diff=0x02, borrow_out=0, busy high for 8 cycles.
REQ-025 The bench SHALL cover: WIDTH=8, a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; then a=0xAA, b=0xAA -> diff=0x00, borrow_out=0.
REQ-026 The bench SHALL cover: start held high continuously with a=0x10, b=0x20 -> results (diff=0xF0, borrow_out=1) every 10 cycles; operand changes and start during RUN and DONE ignored.
REQ-027 The bench SHALL cover: rst asserted on the 4th RUN cycle -> outputs 0 immediately, no done pulse; after release a=0x7F, b=0x80 -> diff=0xFF, borrow_out=1.
REQ-028 The bench SHALL cover: WIDTH=4, a=0x3, b=0x9 -> diff=0xA, borrow_out=1, done 4 edges after start.
REQ-029 The bench SHALL cover: a random sweep of 1000 operand pairs at WIDTH=8 -> {borrow_out,diff} equals the 9-bit result of a-b every time.
